reg_access_arbiter: RTL and testbench

- Shares the single access port of the configuration/status register bank between NUM_REQ host front-ends (requester 0 = SPI peripheral, requester 1 = I2C peripheral).
- Handles round-robin arbitration, address decode, write protection of read-only registers, and req/ack handshake sequencing.
- Sits between the protocol front-ends and the register bank, inside the top wrapper, on the system clock domain.

---
 rtl/reg_bank_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/reg_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_reg_access_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and constants for the register-bank access path:
//   - default geometry of the config/status register bank
//   - FSM state encoding of the access arbiter
//   - address decode helper classifying an address as rw / ro / error
// ---------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DEF_REG_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_CFG    = 8;
    localparam int DEF_NUM_STATUS = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DEC_RW  = 2'd0,
        DEC_RO  = 2'd1,
        DEC_ERR = 2'd2
    } dec_e;

    // Config registers sit at the bottom of the map, status registers
    // directly above them; anything higher is unmapped.
    function automatic dec_e addr_decode(input int unsigned addr,
                                         input int unsigned num_cfg,
                                         input int unsigned num_status);
        if (addr < num_cfg)
            return DEC_RW;
        else if (addr < num_cfg + num_status)
            return DEC_RO;
        else
            return DEC_ERR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority picker. The search begins at ptr_i and
// wraps around; the first requester found wins. The pointer itself is kept
// by the parent.
//   req_i     in  NUM_REQ  request vector
//   ptr_i     in  PTR_W    index where the search starts
//   gnt_o     out NUM_REQ  one-hot grant (all zero if no request)
//   gnt_idx_o out PTR_W    index of the granted requester
//   any_o     out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
// Shares the single register-bank port between NUM_REQ host front-ends.
// One transfer at a time: arbitrate (IDLE), drive the bank (ACCESS), return
// ack/err/rdata (RESP), then hold the grant until the winner drops its
// request (RELEASE) so a level request is never serviced twice.
//   clk, rstb     system clock, async active-low reset
//   ena           clock enable, all state holds when low
//   req_i/we_i    per-requester request level and write flag
//   addr_i        flattened addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_i       flattened write data, requester k at [k*REG_WIDTH +: REG_WIDTH]
//   gnt_o         one-hot grant, held from arbitration until release
//   ack_o         one-cycle completion pulse to the winner
//   err_o/rdata_o response, updated per transfer, held in between
//   bank_*        register bank access port
// ---------------------------------------------------------------------------
module reg_access_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_CFG    = DEF_NUM_CFG,
    parameter int NUM_STATUS = DEF_NUM_STATUS,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*REG_WIDTH-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic                          err_o,
    output logic [REG_WIDTH-1:0]          rdata_o,
    output logic                          bank_we_o,
    output logic                          bank_re_o,
    output logic [ADDR_WIDTH-1:0]         bank_addr_o,
    output logic [REG_WIDTH-1:0]          bank_wdata_o,
    input  logic [REG_WIDTH-1:0]          bank_rdata_i
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;       // next search start
    logic [PTR_W-1:0]        win_q, win_d;       // latched winner index
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
    logic [REG_WIDTH-1:0]    rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [PTR_W-1:0]        arb_idx;
    logic                    arb_any;

    dec_e                    dec;
    logic                    acc_err, wr_ok, rd_ok;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // Writes to status registers are rejected just like unmapped addresses.
    assign dec     = addr_decode(32'(addr_q), NUM_CFG, NUM_STATUS);
    assign acc_err = (dec == DEC_ERR) || (we_q && dec == DEC_RO);
    assign wr_ok   = we_q && !acc_err;
    assign rd_ok   = !we_q && !acc_err;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arb_any) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = ST_RESP;
            ST_RESP:    state_d = ST_RELEASE;
            ST_RELEASE: if (!req_i[win_q]) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_comb begin
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    win_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    we_d    = we_i[arb_idx];
                    addr_d  = addr_i[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = wdata_i[int'(arb_idx)*REG_WIDTH +: REG_WIDTH];
                end
            end
            ST_ACCESS: begin
                // Captured here so the response is stable from the first
                // RESP cycle until the next transfer's RESP.
                rdata_d = rd_ok ? bank_rdata_i : '0;
                err_d   = acc_err;
            end
            ST_RESP: begin
                ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            ST_RELEASE: begin
                if (!req_i[win_q]) gnt_d = '0;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        bank_we_o = (state_q == ST_ACCESS) && wr_ok;
        bank_re_o = (state_q == ST_ACCESS) && rd_ok;
        ack_o     = (state_q == ST_RESP) ? gnt_q : '0;
    end

    assign gnt_o        = gnt_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign bank_addr_o  = addr_q;
    assign bank_wdata_o = wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_access_arbiter
// Directed bench for reg_access_arbiter with a behavioural register bank.
// Bank contents start at mem[a] = a + 7 so reads have known values.
// ---------------------------------------------------------------------------
module tb_reg_access_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [1:0]  req_i, we_i;
    logic [7:0]  addr_i;
    logic [15:0] wdata_i;
    logic [1:0]  gnt_o, ack_o;
    logic        err_o;
    logic [7:0]  rdata_o;
    logic        bank_we_o, bank_re_o;
    logic [3:0]  bank_addr_o;
    logic [7:0]  bank_wdata_o, bank_rdata_i;

    always #5 clk = ~clk;

    reg_access_arbiter dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .bank_we_o    (bank_we_o),
        .bank_re_o    (bank_re_o),
        .bank_addr_o  (bank_addr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_rdata_i (bank_rdata_i)
    );

    // Behavioural bank
    logic [7:0] mem [16];
    logic       mem_ok = 1'b0;
    assign bank_rdata_i = mem[bank_addr_o];
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 7);
            mem_ok <= 1'b1;
        end else if (bank_we_o) begin
            mem[bank_addr_o] <= bank_wdata_o;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Invariants every cycle, plus a log of ack rising edges
    logic [1:0] ack_prev = 2'b00;
    int         ack_log[$];
    always @(negedge clk) begin
        if (rstb === 1'b1) begin
            chk("gnt_onehot", 32'($countones(gnt_o) <= 1), 1);
            chk("strobe_excl", 32'(bank_we_o && bank_re_o), 0);
        end
        for (int k = 0; k < 2; k++)
            if (ack_o[k] && !ack_prev[k]) ack_log.push_back(k);
        ack_prev <= ack_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int k, input string tag);
        int n = 0;
        while (!ack_o[k] && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(ack_o[k]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstb = 1'b0; ena = 1'b1;
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        step(); step();
        chk("rst_gnt",   32'(gnt_o), 0);
        chk("rst_ack",   32'(ack_o), 0);
        chk("rst_err",   32'(err_o), 0);
        chk("rst_rdata", 32'(rdata_o), 0);
        chk("rst_strb",  32'({bank_we_o, bank_re_o}), 0);
        chk("rst_addr",  32'(bank_addr_o), 0);
        #2 rstb = 1'b1;
        step();

        // Requester 0 writes cfg 0x0 = 0xA5
        req_i = 2'b01; we_i = 2'b01; addr_i[3:0] = 4'h0; wdata_i[7:0] = 8'hA5;
        step();
        chk("t1_we",    32'(bank_we_o), 1);
        chk("t1_re",    32'(bank_re_o), 0);
        chk("t1_addr",  32'(bank_addr_o), 0);
        chk("t1_wdata", 32'(bank_wdata_o), 32'h A5);
        chk("t1_gnt",   32'(gnt_o), 1);
        chk("t1_noack", 32'(ack_o), 0);
        step();
        chk("t1_ack",   32'(ack_o), 1);
        chk("t1_err",   32'(err_o), 0);
        chk("t1_weoff", 32'(bank_we_o), 0);
        req_i = 2'b00;
        step();
        chk("t1_relgnt", 32'(gnt_o), 1);
        chk("t1_relack", 32'(ack_o), 0);
        step();
        chk("t1_idlegnt", 32'(gnt_o), 0);
        chk("t1_mem0",   32'(mem[0]), 32'h A5);

        // Requester 1 reads status 0x9 (bank returns 0x10)
        req_i = 2'b10; we_i = 2'b00; addr_i[7:4] = 4'h9;
        step();
        chk("t2_re",   32'(bank_re_o), 1);
        chk("t2_addr", 32'(bank_addr_o), 9);
        chk("t2_gnt",  32'(gnt_o), 2);
        step();
        chk("t2_ack",   32'(ack_o), 2);
        chk("t2_rdata", 32'(rdata_o), 32'h10);
        chk("t2_err",   32'(err_o), 0);
        req_i = 2'b00;
        step(); step();

        // Both requesters read simultaneously, four rounds
        ack_log.delete();
        for (int r = 0; r < 4; r++) begin
            addr_i = {4'hA, 4'h1}; we_i = 2'b00; req_i = 2'b11;
            wait_ack(0, "t4_ack0");
            chk("t4_rdata0", 32'(rdata_o), 8);
            chk("t4_gnt0",   32'(gnt_o), 1);
            req_i[0] = 1'b0;
            wait_ack(1, "t4_ack1");
            chk("t4_rdata1", 32'(rdata_o), 32'h11);
            chk("t4_gnt1",   32'(gnt_o), 2);
            req_i[1] = 1'b0;
            step(); step(); step();
        end
        chk("t4_count", 32'(ack_log.size()), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            chk("t4_order", 32'(ack_log[i]), 32'(i % 2));

        // Requester 0 writes a read-only address
        req_i = 2'b01; we_i = 2'b01; addr_i[3:0] = 4'hC; wdata_i[7:0] = 8'hFF;
        step();
        chk("t3_strb", 32'({bank_we_o, bank_re_o}), 0);
        chk("t3_gnt",  32'(gnt_o), 1);
        step();
        chk("t3_ack",   32'(ack_o), 1);
        chk("t3_err",   32'(err_o), 1);
        chk("t3_rdata", 32'(rdata_o), 0);
        req_i = 2'b00;
        step(); step();
        chk("t3_memC", 32'(mem[12]), 32'h13);

        // Reset during ACCESS of a requester-1 write; pointer was at 1
        req_i = 2'b10; we_i = 2'b10; addr_i[7:4] = 4'h3; wdata_i[15:8] = 8'h5A;
        step();
        chk("t5_we",  32'(bank_we_o), 1);
        chk("t5_gnt", 32'(gnt_o), 2);
        #2 rstb = 1'b0;
        #1;
        chk("t5_rst_strb", 32'({bank_we_o, bank_re_o}), 0);
        chk("t5_rst_gnt",  32'(gnt_o), 0);
        chk("t5_rst_ack",  32'(ack_o), 0);
        chk("t5_rst_err",  32'(err_o), 0);
        chk("t5_rst_addr", 32'(bank_addr_o), 0);
        chk("t5_rst_wd",   32'(bank_wdata_o), 0);
        req_i = 2'b00;
        step();
        chk("t5_mem3", 32'(mem[3]), 32'h0A);
        #2 rstb = 1'b1;
        step();
        req_i = 2'b11; we_i = 2'b00; addr_i = {4'hA, 4'h1};
        step();
        chk("t5_first_gnt", 32'(gnt_o), 1);
        step();
        chk("t5_ack", 32'(ack_o), 1);
        req_i = 2'b00;
        step(); step();

        // Clock enable dropped while in RESP
        ack_log.delete();
        req_i = 2'b10; we_i = 2'b00; addr_i[7:4] = 4'h5;
        step();
        step();
        chk("t6_ack",   32'(ack_o), 2);
        chk("t6_rdata", 32'(rdata_o), 32'h0C);
        ena = 1'b0;
        repeat (5) begin
            step();
            chk("t6_frz_ack", 32'(ack_o), 2);
            chk("t6_frz_gnt", 32'(gnt_o), 2);
        end
        ena = 1'b1;
        step();
        chk("t6_rel_ack", 32'(ack_o), 0);
        chk("t6_rel_gnt", 32'(gnt_o), 2);
        req_i = 2'b00;
        step();
        chk("t6_idle_gnt", 32'(gnt_o), 0);
        chk("t6_acks", 32'(ack_log.size()), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
